ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage RV32 core.
- Consumes the operand, ALU-control and control fields driven by the ID/EX latch, computes the result, and registers it toward MEM.
- Single-cycle for ADD, SUB, AND and OR. MUL runs on an iterative shift-add multiplier and stalls the upstream stages while it is busy.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits consumed per iteration. Legal values are 1, 2, 4, 8. N = 32 / BITS_PER_CYCLE iterations.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- val1_i  in  32  operand A from ID/EX
- val2_i  in  32  operand B (already muxed rs2 or imm) from ID/EX
- ALUCtrl_i  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul
- Simm_i  in  32  store-path data from ID/EX
- rd_addr_i  in  5  destination register
- Mem_i  in  2  memory control, passed through
- WB_i  in  1  register-write enable, passed through
- stall_o  out  1  combinational; holds PC, IF/ID and ID/EX when high
- result_o  out  32  registered ALU/MUL result
- Simm_o  out  32  registered
- rd_addr_o  out  5  registered
- Mem_o  out  2  registered
- WB_o  out  1  registered

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE, counter 0, all registered outputs 0. stall_o=0 while in reset.
- States: IDLE, BUSY.
- IDLE, non-mul ALUCtrl:
  - Next posedge writes result_o = op(val1_i, val2_i), along with Simm_o, rd_addr_o, Mem_o, WB_o.
  - stall_o = 0. Latency is 1 cycle.
  - Arithmetic is 32-bit, wrap-around, no flags.
- Unknown ALUCtrl codes give result 0; control fields still pass through.
- IDLE, ALUCtrl=1111:
  - stall_o = 1 (combinational).
  - Posedge captures multiplicand=val1_i, multiplier=val2_i, accumulator=0, counter=0, and latches rd, Mem, WB and Simm internally.
  - EX/MEM is written with a bubble: all fields 0. Next state BUSY.
- BUSY:
  - Inputs are ignored. The ID/EX latch still shows the mul and must not re-trigger.
  - Each posedge: accumulator += multiplicand × low BITS_PER_CYCLE bits of multiplier; multiplicand shifts left by BITS_PER_CYCLE; multiplier shifts right by BITS_PER_CYCLE; counter increments.
  - last = (counter == N-1).
  - stall_o = !last.
  - Non-last edges write a bubble to EX/MEM.
  - Last edge writes result_o = low 32 bits of the final accumulator plus the latched control fields, then returns to IDLE. ID/EX advances on the same edge.
- stall_o is high for exactly N consecutive cycles per MUL, and the MUL occupies N+1 cycles.
- A MUL followed immediately by another MUL re-enters BUSY from IDLE the cycle after completion. No idle gap is required beyond that IDLE cycle.
- Reset asserted mid-MUL: the operation is abandoned, outputs are zeroed and the state is IDLE. No result is written.

Optional Feature:
- Macro: EX_MUL_ZERO_SKIP_EN.
- Defined: last = (counter == N-1) OR (multiplier after the current shift == 0). The multiply terminates early, with at least 1 BUSY cycle. Results are identical.
- Undefined: fixed N BUSY cycles.

Decomposition:
- Package ex_pkg holds:
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL.
  - State enum: IDLE, BUSY.
  - Bubble constant for the EX/MEM fields.
- Sub-module seq_mul owns the multiplier datapath:
  - Registers: multiplicand, multiplier, accumulator.
  - Handshake: start/last.
- ex_mem_stage owns the FSM, stall_o, the single-cycle ALU and the EX/MEM register.

Test Plan:
- Add: val1=5, val2=3, ALUCtrl=0010, rd=7, WB=1 → next edge result_o=8, rd_addr_o=7, WB_o=1; stall_o never high.
- Sub and logic: 3-5 → 0xFFFFFFFE; 0xF0F0 AND 0x0FF0 → 0x00F0; 0xF000 OR 0x000F → 0xF00F, each one cycle.
- MUL, BPC=1, no macro: 7×6, WB=1, rd=9.
  - stall_o high 32 cycles.
  - EX/MEM shows 32 bubbles (WB_o=0).
  - Then result_o=42, rd_addr_o=9, WB_o=1.
- MUL wrap and other widths: 0xFFFFFFFF×2 → 0xFFFFFFFE. Repeat with BPC=4 and check stall_o high 8 cycles.
- Reset mid-MUL: assert rst_i low at BUSY cycle 10 → all outputs 0 immediately, stall_o=0, state IDLE. A later ADD works normally.
- EX_MUL_ZERO_SKIP_EN, BPC=1: 3×5 → stall_o high 3 cycles, result_o=15. 9×0 → stall_o high 1 cycle, result_o=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU control codes, FSM states,
// the EX/MEM register layout and the single-cycle ALU function.
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] simm;
    logic [4:0]  rd_addr;
    logic [1:0]  mem;
    logic        wb;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  // Unknown codes (including MUL, which is handled elsewhere) yield zero.
  function automatic logic [31:0] alu_op(input logic [3:0] ctrl,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (ctrl)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_stage_seq_mul.sv
// Iterative shift-add multiplier consuming BITS_PER_CYCLE multiplier bits per step.
// Early termination on an exhausted multiplier is enabled by EX_MUL_ZERO_SKIP_EN.
module seq_mul
  import ex_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic        run,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        last,
  output logic [31:0] product
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  logic [31:0]   mcand_reg;
  logic [31:0]   mplier_reg;
  logic [31:0]   acc_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   mplier_shift;
  logic [31:0]   partial;
  logic [31:0]   term [BITS_PER_CYCLE];

  // One shifted copy of the multiplicand per multiplier bit consumed this step.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      partial = partial + term[i];
    end
  end

  assign product      = acc_reg + partial;
  assign mplier_shift = mplier_reg >> BITS_PER_CYCLE;

`ifdef EX_MUL_ZERO_SKIP_EN
  assign last = (count_reg == CW'(N - 1)) || (mplier_shift == 32'd0);
`else
  assign last = (count_reg == CW'(N - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (run) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
      mplier_reg <= mplier_shift;
      count_reg  <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: single-cycle ALU plus a stalling iterative MUL.
// Define EX_MUL_ZERO_SKIP_EN to let the multiplier finish early.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [3:0]  ALUCtrl_i,
  input  logic [31:0] Simm_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  Mem_i,
  input  logic        WB_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [31:0] Simm_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  Mem_o,
  output logic        WB_o
);

  state_t      state_reg, state_next;
  ex_mem_t     ex_mem_reg, ex_mem_next;
  ex_mem_t     ctl_reg;
  logic        stall;
  logic        mul_start;
  logic        mul_run;
  logic        mul_last;
  logic [31:0] mul_product;

  seq_mul #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_seq_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (mul_start),
    .run    (mul_run),
    .a      (val1_i),
    .b      (val2_i),
    .last   (mul_last),
    .product(mul_product)
  );

  always_comb begin
    state_next  = state_reg;
    ex_mem_next = EX_MEM_BUBBLE;
    stall       = 1'b0;
    mul_start   = 1'b0;
    mul_run     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ALUCtrl_i == ALU_MUL) begin
          stall      = 1'b1;
          mul_start  = 1'b1;
          state_next = BUSY;
        end else begin
          ex_mem_next = '{result:  alu_op(ALUCtrl_i, val1_i, val2_i),
                          simm:    Simm_i,
                          rd_addr: rd_addr_i,
                          mem:     Mem_i,
                          wb:      WB_i};
        end
      end
      BUSY: begin
        // ID/EX still holds the MUL here; its fields are deliberately ignored.
        mul_run = 1'b1;
        stall   = !mul_last;
        if (mul_last) begin
          ex_mem_next        = ctl_reg;
          ex_mem_next.result = mul_product;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      ex_mem_reg <= EX_MEM_BUBBLE;
      ctl_reg    <= EX_MEM_BUBBLE;
    end else begin
      state_reg  <= state_next;
      ex_mem_reg <= ex_mem_next;
      if (mul_start) begin
        ctl_reg <= '{result: 32'd0, simm: Simm_i, rd_addr: rd_addr_i,
                     mem: Mem_i, wb: WB_i};
      end
    end
  end

  // Reset forces stall low even though the ID/EX latch may still show a MUL.
  assign stall_o   = stall & rst_i;
  assign result_o  = ex_mem_reg.result;
  assign Simm_o    = ex_mem_reg.simm;
  assign rd_addr_o = ex_mem_reg.rd_addr;
  assign Mem_o     = ex_mem_reg.mem;
  assign WB_o      = ex_mem_reg.wb;

endmodule
